// File: rtl/move_arbiter.sv
// Debounced four-button move arbiter with a valid/ready command handshake and a sticky lockout once the board raises flag.
// Defining MOVE_RR_ARB_EN selects round-robin arbitration; otherwise fixed priority izquierda > derecha > arriba > abajo.
//   state   | meaning
//   S_IDLE  | no command offered; arbitrate pending presses
//   S_ISSUE | latched command offered until move_ready
//   S_LOCK  | game over; code 101 until reset
module move_arbiter #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_izquierda,
    input  logic       btn_derecha,
    input  logic       btn_arriba,
    input  logic       btn_abajo,
    input  logic       flag,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [2:0] move_code,
    output logic       locked
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LOCK} state_t;

    state_t        state;
    logic [3:0]    btn_raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    pressed;
    logic [3:0]    db;
    logic [3:0]    db_q;
    logic [3:0]    rise;
    logic [3:0]    pending;
    logic [3:0]    clr_mask;
    logic [CW-1:0] cnt [4];
    logic [1:0]    grant_idx;
    logic [1:0]    win_idx;
    logic          win_any;
    logic          xfer;

    // Bit order is also the fixed priority order: bit 0 = izquierda.
    assign btn_raw = {btn_abajo, btn_arriba, btn_derecha, btn_izquierda};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign pressed = ~sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db   <= '0;
            db_q <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            db_q <= db;
            for (int i = 0; i < 4; i++) begin
                if (pressed[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    db[i]  <= pressed[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign rise     = db & ~db_q;
    assign xfer     = (state == S_ISSUE) && move_ready;
    assign clr_mask = xfer ? (4'b0001 << grant_idx) : 4'b0000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pending <= '0;
        else if (state == S_LOCK)
            pending <= '0;
        else
            pending <= (pending | rise) & ~clr_mask;
    end

`ifdef MOVE_RR_ARB_EN
    logic [1:0] rr_ptr;
    logic [1:0] rr_idx;

    // Scan from the farthest offset down so the nearest pending button at or after the pointer wins.
    always_comb begin
        win_any = |pending;
        win_idx = rr_ptr;
        rr_idx  = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            rr_idx = rr_ptr + 2'(k);
            if (pending[rr_idx]) win_idx = rr_idx;
        end
    end

    // A move dropped by flag is not a transfer, so the pointer stays put.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_ptr <= '0;
        else if (xfer)
            rr_ptr <= grant_idx + 2'd1;
    end
`else
    always_comb begin
        win_any = |pending;
        win_idx = '0;
        for (int k = 3; k >= 0; k--) begin
            if (pending[k]) win_idx = 2'(k);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            move_valid <= 1'b0;
            move_code  <= 3'b000;
            locked     <= 1'b0;
            grant_idx  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (flag) begin
                        state      <= S_LOCK;
                        move_valid <= 1'b0;
                        move_code  <= 3'b101;
                        locked     <= 1'b1;
                    end else if (win_any) begin
                        state      <= S_ISSUE;
                        grant_idx  <= win_idx;
                        move_valid <= 1'b1;
                        move_code  <= {1'b0, win_idx} + 3'd1;
                    end
                end
                S_ISSUE: begin
                    if (flag) begin
                        state      <= S_LOCK;
                        move_valid <= 1'b0;
                        move_code  <= 3'b101;
                        locked     <= 1'b1;
                    end else if (move_ready) begin
                        state      <= S_IDLE;
                        move_valid <= 1'b0;
                        move_code  <= 3'b000;
                    end
                end
                S_LOCK: begin
                    move_valid <= 1'b0;
                    move_code  <= 3'b101;
                    locked     <= 1'b1;
                end
                default: begin
                    state      <= S_IDLE;
                    move_valid <= 1'b0;
                    move_code  <= 3'b000;
                    locked     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_arbiter.sv
// Bench for move_arbiter with DEBOUNCE_CYCLES=4: directed timing scenarios plus randomized press sets
// checked against an ordering model; follows MOVE_RR_ARB_EN for the arbitration rule.
module tb_move_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_izquierda, btn_derecha, btn_arriba, btn_abajo;
    logic       flag, move_ready;
    logic       move_valid;
    logic [2:0] move_code;
    logic       locked;

    int vectors = 0;
    int fails   = 0;
    int exp_ptr = 0;

    move_arbiter #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .btn_izquierda(btn_izquierda), .btn_derecha(btn_derecha),
        .btn_arriba(btn_arriba), .btn_abajo(btn_abajo),
        .flag(flag), .move_ready(move_ready),
        .move_valid(move_valid), .move_code(move_code), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Active-high set of held buttons -> pins (bit 0 = izquierda).
    task automatic drive(input logic [3:0] held);
        btn_izquierda = ~held[0];
        btn_derecha   = ~held[1];
        btn_arriba    = ~held[2];
        btn_abajo     = ~held[3];
    endtask

    task automatic wait_valid(input int limit);
        int n = 0;
        while (!move_valid && n < limit) begin
            tick();
            n++;
        end
        chk("wait_valid", 8'(move_valid), 8'd1);
    endtask

    // Reference arbitration: first pending button scanning from the base position.
    function automatic int pick(input logic [3:0] pend, input int ptr);
        int base;
        base = ptr;
`ifndef MOVE_RR_ARB_EN
        base = 0;
`endif
        for (int k = 0; k < 4; k++)
            if (pend[(base + k) % 4]) return (base + k) % 4;
        return -1;
    endfunction

    initial begin
        int first, second;
        logic [3:0] mask, glitch, pend;
        int glen, ptr, w;
        int exp_q[$];
        int obs_q[$];
        logic pv, pr;
        logic [2:0] pc;

        rst = 1'b0; flag = 1'b0; move_ready = 1'b1;
        drive(4'b0000);
        #2;
        chk("rst_code", 8'(move_code), 8'd0);
        chk("rst_valid", 8'(move_valid), 8'd0);
        chk("rst_locked", 8'(locked), 8'd0);
        #10 rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_code", 8'(move_code), 8'd0);
            chk("idle_valid", 8'(move_valid), 8'd0);
            chk("idle_locked", 8'(locked), 8'd0);
        end

        // Held left press: one command, valid only after edge 8.
        drive(4'b0001);
        for (int e = 0; e < 16; e++) begin
            tick();
            chk("izq_valid", 8'(move_valid), (e == 8) ? 8'd1 : 8'd0);
            chk("izq_code", 8'(move_code), (e == 8) ? 8'd1 : 8'd0);
        end
        exp_ptr = 1;
        drive(4'b0000);
        repeat (12) tick();

        // Three-cycle glitch on derecha.
        drive(4'b0010);
        repeat (3) tick();
        drive(4'b0000);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("glitch_valid", 8'(move_valid), 8'd0);
        end

        // Stalled arriba, then derecha after one idle cycle.
        move_ready = 1'b0;
        drive(4'b0100);
        repeat (2) tick();
        drive(4'b0110);
        wait_valid(30);
        for (int i = 0; i < 10; i++) begin
            chk("stall_code", 8'(move_code), 8'd3);
            chk("stall_valid", 8'(move_valid), 8'd1);
            tick();
        end
        move_ready = 1'b1;
        tick();
        chk("gap_valid", 8'(move_valid), 8'd0);
        chk("gap_code", 8'(move_code), 8'd0);
        tick();
        chk("second_valid", 8'(move_valid), 8'd1);
        chk("second_code", 8'(move_code), 8'd2);
        tick();
        chk("second_done", 8'(move_valid), 8'd0);
        exp_ptr = 2;
        drive(4'b0000);
        repeat (12) tick();

        // Simultaneous izquierda + abajo.
        first  = pick(4'b1001, exp_ptr);
        second = (first == 0) ? 3 : 0;
        drive(4'b1001);
        for (int e = 0; e < 12; e++) begin
            tick();
            chk("dual_valid", 8'(move_valid), (e == 8 || e == 10) ? 8'd1 : 8'd0);
            chk("dual_code", 8'(move_code),
                (e == 8) ? 8'(first + 1) : (e == 10) ? 8'(second + 1) : 8'd0);
        end
        exp_ptr = (second + 1) % 4;
        drive(4'b0000);
        repeat (12) tick();

        // Randomized press sets with random ready back-pressure.
        for (int r = 0; r < 30; r++) begin
            mask   = 4'($urandom_range(1, 15));
            glitch = ~mask & 4'($urandom_range(0, 15));
            glen   = $urandom_range(1, 3);
            exp_q.delete();
            obs_q.delete();
            pend = mask;
            ptr  = exp_ptr;
            while (pend != 4'b0000) begin
                w = pick(pend, ptr);
                exp_q.push_back(w);
                pend[w] = 1'b0;
                ptr = (w + 1) % 4;
            end
            for (int c = 0; c < 60; c++) begin
                drive((c < glen) ? (mask | glitch) : mask);
                move_ready = (c >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
                pv = move_valid; pc = move_code; pr = move_ready;
                tick();
                if (pv && pr) begin
                    obs_q.push_back(int'(pc));
                    chk("rnd_gap", 8'(move_valid), 8'd0);
                end else if (pv) begin
                    chk("rnd_hold_valid", 8'(move_valid), 8'd1);
                    chk("rnd_hold_code", 8'(move_code), 8'(pc));
                end
            end
            chk("rnd_count", 8'(obs_q.size()), 8'(exp_q.size()));
            for (int i = 0; i < exp_q.size(); i++)
                if (i < obs_q.size())
                    chk("rnd_order", 8'(obs_q[i]), 8'(exp_q[i] + 1));
            exp_ptr = ptr;
            drive(4'b0000);
            move_ready = 1'b1;
            repeat (15) tick();
            chk("rnd_quiet", 8'(move_valid), 8'd0);
        end

        // Lockout during a stalled command, then recovery by reset.
        move_ready = 1'b0;
        drive(4'b0100);
        wait_valid(30);
        chk("pre_lock_code", 8'(move_code), 8'd3);
        flag = 1'b1;
        tick();
        chk("lock_code", 8'(move_code), 8'd5);
        chk("lock_flag", 8'(locked), 8'd1);
        chk("lock_valid", 8'(move_valid), 8'd0);
        flag = 1'b0;
        move_ready = 1'b1;
        drive(4'b0010);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("lock_hold_code", 8'(move_code), 8'd5);
            chk("lock_hold_valid", 8'(move_valid), 8'd0);
        end
        rst = 1'b0;
        #1;
        chk("arst_code", 8'(move_code), 8'd0);
        chk("arst_locked", 8'(locked), 8'd0);
        chk("arst_valid", 8'(move_valid), 8'd0);
        drive(4'b0000);
        tick();
        tick();
        rst = 1'b1;
        exp_ptr = 0;
        repeat (3) tick();
        drive(4'b0100);
        for (int e = 0; e < 10; e++) begin
            tick();
            chk("post_valid", 8'(move_valid), (e == 8) ? 8'd1 : 8'd0);
            chk("post_code", 8'(move_code), (e == 8) ? 8'd3 : 8'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
